fitness_sched: RTL and testbench

FITNESS_SCHED -- requirements
Module: fitness_sched

---
 rtl/gaa_pkg.sv | 28 ++
 rtl/fitness_sched.sv | 139 +++++++++++++
 tb/tb_fitness_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/gaa_pkg.sv
// Shared definitions for the fitness evaluation scheduler: FSM states,
// register addresses and CTRL/STATUS bit positions.
package gaa_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_POP   = 3'd1;
    localparam logic [2:0] A_STAT  = 3'd2;
    localparam logic [2:0] A_BIDX  = 3'd3;
    localparam logic [2:0] A_BFITL = 3'd4;
    localparam logic [2:0] A_BFITH = 3'd5;
    localparam logic [2:0] A_CNT   = 3'd6;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLR   = 2;

    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_TOERR = 2;

endpackage

// File: rtl/fitness_sched.sv
// Avalon-MM controlled scheduler: walks a population through an external
// fitness unit one index at a time and tracks the best result seen.
module fitness_sched
    import gaa_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int FIT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             write,
    input  logic             read,
    input  logic [2:0]       address,
    input  logic [7:0]       writedata,
    output logic [7:0]       readdata,
    output logic             irq,
    output logic             eval_req,
    output logic [7:0]       eval_idx,
    input  logic             eval_ack,
    input  logic             res_valid,
    input  logic [FIT_W-1:0] res_fitness
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           r_state, w_nxt;
    logic [7:0]       r_pop, r_idx, r_best_idx, r_count, r_rdata;
    logic [FIT_W-1:0] r_best_fit;
    logic             r_done, r_to_err;
    logic [TW-1:0]    r_tmo;

    logic             w_ctrl, w_start, w_abort, w_clr, w_busy;
    logic             w_tmo_hit, w_rec, w_last;
    logic [FIT_W-1:0] w_fit;
    logic [15:0]      w_fit16;
    logic [7:0]       w_rmux;
    logic             w_unused_ok;

    assign w_ctrl    = chipselect && write && (address == A_CTRL);
    assign w_abort   = w_ctrl && writedata[CTRL_ABORT];
    // START only counts from IDLE and loses to ABORT in the same write
    assign w_start   = w_ctrl && writedata[CTRL_START] && !w_abort && (r_state == S_IDLE);
    assign w_clr     = w_ctrl && writedata[CTRL_CLR];
    assign w_busy    = (r_state != S_IDLE);
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT));
    assign w_rec     = (r_state == S_WAIT) && (res_valid || w_tmo_hit);
    assign w_fit     = res_valid ? res_fitness : '0;
    assign w_last    = ((r_idx + 8'd1) == r_pop);
    assign w_fit16   = 16'(r_best_fit);
    assign w_unused_ok = &{1'b0, writedata[7:3]};

    assign readdata = r_rdata;
    assign irq      = r_done;
    assign eval_req = (r_state == S_ISSUE);
    assign eval_idx = r_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (w_abort) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_nxt = (r_pop == 8'd0) ? S_DONE : S_ISSUE;
                S_ISSUE: if (eval_ack) w_nxt = S_WAIT;
                S_WAIT:  if (w_rec) w_nxt = w_last ? S_DONE : S_ISSUE;
                S_DONE:  w_nxt = S_IDLE;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pop      <= '0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_fit <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_to_err   <= 1'b0;
            r_tmo      <= '0;
        end else begin
            if (chipselect && write && (address == A_POP) && !w_busy)
                r_pop <= writedata;

            if (r_state == S_ISSUE && eval_ack)
                r_tmo <= '0;
            else if (r_state == S_WAIT && !w_tmo_hit)
                r_tmo <= r_tmo + TW'(1);

            if (w_start) begin
                r_best_idx <= '0;
                r_best_fit <= '0;
                r_count    <= '0;
                r_to_err   <= 1'b0;
                r_idx      <= '0;
            end

            // A timed-out slot is recorded as fitness 0; ties keep the earlier index
            if (w_rec && !w_abort) begin
                if (w_fit > r_best_fit || r_count == 8'd0) begin
                    r_best_fit <= w_fit;
                    r_best_idx <= r_idx;
                end
                if (r_count != 8'hFF) r_count <= r_count + 8'd1;
                if (!res_valid)       r_to_err <= 1'b1;
                if (!w_last)          r_idx <= r_idx + 8'd1;
            end

            if (w_start || w_clr || w_abort) r_done <= 1'b0;
            if (w_nxt == S_DONE)             r_done <= 1'b1;
        end
    end

    always_comb begin
        w_rmux = 8'd0;
        case (address)
            A_POP:   w_rmux = r_pop;
            A_STAT:  w_rmux = {5'd0, r_to_err, r_done, w_busy};
            A_BIDX:  w_rmux = r_best_idx;
            A_BFITL: w_rmux = w_fit16[7:0];
            A_BFITH: w_rmux = w_fit16[15:8];
            A_CNT:   w_rmux = r_count;
            default: w_rmux = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_rdata <= '0;
        else if (chipselect && read) r_rdata <= w_rmux;
    end

endmodule

// File: tb/tb_fitness_sched.sv
// Self-checking bench for fitness_sched: register reads and issued indices
// are checked against expectations queued when the stimulus is driven.
module tb_fitness_sched;

    logic        clk, reset, chipselect, write, read;
    logic [2:0]  address;
    logic [7:0]  writedata, readdata, eval_idx;
    logic        irq, eval_req, eval_ack, res_valid;
    logic [15:0] res_fitness;

    int n_chk = 0;
    int n_fail = 0;
    int req_cnt = 0;

    logic [7:0] rd_q[$];
    string      tag_q[$];
    logic [7:0] idx_q[$];

    fitness_sched #(.TIMEOUT(8), .FIT_W(16)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .irq(irq), .eval_req(eval_req),
        .eval_idx(eval_idx), .eval_ack(eval_ack), .res_valid(res_valid),
        .res_fitness(res_fitness)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (eval_req) req_cnt <= req_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        rd_q.push_back(exp);
        tag_q.push_back(tag);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        chk(tag_q.pop_front(), readdata, rd_q.pop_front());
    endtask

    // Fitness unit model: wait for request, ack after ack_dly, optionally return fit
    task automatic serve(input logic [7:0] idx, input logic [15:0] fit,
                         input int ack_dly, input bit send);
        int n;
        n = 0;
        idx_q.push_back(idx);
        while (!eval_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!eval_req) begin
            chk("eval_req_wait", 0, 1);
            void'(idx_q.pop_front());
            return;
        end
        chk("eval_idx", eval_idx, idx_q.pop_front());
        repeat (ack_dly) @(negedge clk);
        eval_ack = 1'b1;
        @(negedge clk);
        eval_ack = 1'b0;
        if (send) begin
            @(negedge clk);
            res_valid = 1'b1; res_fitness = fit;
            @(negedge clk);
            res_valid = 1'b0;
        end
    endtask

    task automatic wait_irq(input int bound, input string tag);
        int n;
        n = 0;
        while (!irq && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, irq, 1);
    endtask

    initial begin
        int base;
        bit stable;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; eval_ack = 1'b0; res_valid = 1'b0;
        res_fitness = '0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_eval_req", eval_req, 0);
        chk("rst_eval_idx", eval_idx, 0);
        reset = 1'b0;
        @(negedge clk);
        rd(3'd1, 8'd0, "rst_pop");
        rd(3'd2, 8'd0, "rst_status");
        rd(3'd6, 8'd0, "rst_count");

        // Normal run with a tie at the best value
        wr(3'd1, 8'd4);
        wr(3'd0, 8'd1);
        serve(8'd0, 16'd10, 2, 1);
        serve(8'd1, 16'd40, 2, 1);
        serve(8'd2, 16'd40, 2, 1);
        serve(8'd3, 16'd5, 2, 1);
        wait_irq(10, "run_irq");
        @(negedge clk);
        rd(3'd2, 8'd2, "run_status");
        rd(3'd3, 8'd1, "run_best_idx");
        rd(3'd4, 8'd40, "run_best_fit_lo");
        rd(3'd5, 8'd0, "run_best_fit_hi");
        rd(3'd6, 8'd4, "run_count");
        rd(3'd7, 8'd0, "reg7_zero");

        // Empty population
        wr(3'd1, 8'd0);
        base = req_cnt;
        wr(3'd0, 8'd1);
        wait_irq(2, "pop0_irq");
        repeat (2) @(negedge clk);
        rd(3'd2, 8'd2, "pop0_status");
        rd(3'd4, 8'd0, "pop0_best_fit");
        rd(3'd6, 8'd0, "pop0_count");
        chk("pop0_no_req", req_cnt - base, 0);

        // Timeout on first individual
        wr(3'd1, 8'd2);
        wr(3'd0, 8'd1);
        serve(8'd0, 16'd0, 1, 0);
        serve(8'd1, 16'd3, 1, 1);
        wait_irq(10, "to_irq");
        @(negedge clk);
        rd(3'd2, 8'd6, "to_status");
        rd(3'd3, 8'd1, "to_best_idx");
        rd(3'd4, 8'd3, "to_best_fit");
        rd(3'd6, 8'd2, "to_count");

        // Abort after third result
        wr(3'd1, 8'd10);
        wr(3'd0, 8'd1);
        serve(8'd0, 16'd1, 1, 1);
        serve(8'd1, 16'd2, 1, 1);
        serve(8'd2, 16'd3, 1, 1);
        wr(3'd0, 8'd2);
        chk("abort_eval_req", eval_req, 0);
        rd(3'd2, 8'd0, "abort_status");
        res_valid = 1'b1; res_fitness = 16'd99;
        @(negedge clk);
        res_valid = 1'b0;
        rd(3'd6, 8'd3, "abort_count");
        rd(3'd4, 8'd3, "abort_best_fit");
        rd(3'd3, 8'd2, "abort_best_idx");

        // Stalled ack, with START and POP_SIZE writes while busy
        wr(3'd1, 8'd3);
        wr(3'd0, 8'd1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!(eval_req === 1'b1 && eval_idx === 8'd0)) stable = 1'b0;
            if (i == 5)      wr(3'd0, 8'd1);
            else if (i == 9) wr(3'd1, 8'd7);
            else             @(negedge clk);
        end
        chk("hold_stable", stable, 1);
        serve(8'd0, 16'd5, 0, 1);
        serve(8'd1, 16'd6, 0, 1);
        serve(8'd2, 16'd7, 0, 1);
        wait_irq(10, "hold_irq");
        @(negedge clk);
        rd(3'd1, 8'd3, "hold_pop");
        rd(3'd6, 8'd3, "hold_count");
        rd(3'd3, 8'd2, "hold_best_idx");
        rd(3'd4, 8'd7, "hold_best_fit");

        // Reset during WAIT, late result afterwards
        wr(3'd1, 8'd2);
        wr(3'd0, 8'd1);
        serve(8'd0, 16'd0, 1, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        res_valid = 1'b1; res_fitness = 16'd50;
        @(negedge clk);
        res_valid = 1'b0;
        @(negedge clk);
        chk("rst2_readdata", readdata, 0);
        chk("rst2_irq", irq, 0);
        chk("rst2_eval_req", eval_req, 0);
        chk("rst2_eval_idx", eval_idx, 0);
        rd(3'd1, 8'd0, "rst2_pop");
        rd(3'd2, 8'd0, "rst2_status");
        rd(3'd3, 8'd0, "rst2_best_idx");
        rd(3'd4, 8'd0, "rst2_best_fit_lo");
        rd(3'd5, 8'd0, "rst2_best_fit_hi");
        rd(3'd6, 8'd0, "rst2_count");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
